jtdd_gfx_rom_arb: RTL and testbench

Shares one 16-bit graphics ROM/SDRAM read port between three tile/sprite fetchers: char (slot 0), scroll (slot 1) and object (slot 2).
- Each fetcher drives an address plus chip-select and waits for an ok flag, which means the data it sees belongs to the address it is presenting now.
- The arbiter keeps a one-word cache per slot.
- It issues requests to the memory port in round-robin order and adds a per-slot base offset to each address.
- It sits between the video layer modules and the SDRAM controller in the game top level.

---
 rtl/jtdd_gfx_rom_arb.sv | 139 +++++++++++++
 tb/tb_jtdd_gfx_rom_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_gfx_rom_arb.sv
// Graphics ROM arbiter: char/scroll/object fetchers share one 16-bit read
// port, each slot holding a one-word cache, served round-robin.
module jtdd_gfx_rom_arb #(
    parameter int          AW0  = 17,
    parameter int          AW1  = 18,
    parameter int          AW2  = 19,
    parameter int          OW   = 22,
    parameter logic [OW-1:0] OFF0 = 22'h00000,
    parameter logic [OW-1:0] OFF1 = 22'h20000,
    parameter logic [OW-1:0] OFF2 = 22'h60000
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           char_cs,
    input  logic [AW0-1:0] char_addr,
    output logic [15:0]    char_data,
    output logic           char_ok,
    input  logic           scr_cs,
    input  logic [AW1-1:0] scr_addr,
    output logic [15:0]    scr_data,
    output logic           scr_ok,
    input  logic           obj_cs,
    input  logic [AW2-1:0] obj_addr,
    output logic [15:0]    obj_data,
    output logic           obj_ok,
    output logic           mem_req,
    output logic [OW-1:0]  mem_addr,
    input  logic           mem_ack,
    input  logic           mem_rdy,
    input  logic [15:0]    mem_dout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    rr;
    logic [1:0]    sel;
    logic [OW-1:0] lat_addr;
    logic [OW-1:0] addr_x      [3];
    logic [OW-1:0] cached_addr [3];
    logic [15:0]   cached_data [3];
    logic [2:0]    valid;
    logic [2:0]    cs;
    logic [2:0]    ok;
    logic [2:0]    pending;
    logic [1:0]    pick;
    logic          found;
    logic [OW-1:0] off_sel;
    logic          done;

    assign cs        = {obj_cs, scr_cs, char_cs};
    assign addr_x[0] = {{(OW-AW0){1'b0}}, char_addr};
    assign addr_x[1] = {{(OW-AW1){1'b0}}, scr_addr};
    assign addr_x[2] = {{(OW-AW2){1'b0}}, obj_addr};

    // ok follows the live address so it drops the moment the address moves
    always_comb begin
        for (int i = 0; i < 3; i++)
            ok[i] = cs[i] & valid[i] & (addr_x[i] == cached_addr[i]);
    end

    assign pending   = cs & ~ok;
    assign char_ok   = ok[0];
    assign scr_ok    = ok[1];
    assign obj_ok    = ok[2];
    assign char_data = cached_data[0];
    assign scr_data  = cached_data[1];
    assign obj_data  = cached_data[2];

    // first pending slot at or after the round-robin pointer
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (int'(rr) + k) % 3;
            if (!found && pending[j]) begin
                found = 1'b1;
                pick  = 2'(j);
            end
        end
    end

    always_comb begin
        case (pick)
            2'd1:    off_sel = OFF1;
            2'd2:    off_sel = OFF2;
            default: off_sel = OFF0;
        endcase
    end

    assign done = (state == WAIT && mem_rdy) ||
                  (state == REQ && mem_ack && mem_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 2'd0;
            sel      <= 2'd0;
            lat_addr <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            valid    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cached_addr[i] <= '0;
                cached_data[i] <= 16'h0000;
            end
        end else begin
            case (state)
                IDLE: if (found) begin
                    sel      <= pick;
                    lat_addr <= addr_x[pick];
                    mem_addr <= off_sel + addr_x[pick];
                    mem_req  <= 1'b1;
                    rr       <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    state    <= REQ;
                end
                REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= mem_rdy ? IDLE : WAIT;
                end
                WAIT: if (mem_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (done) begin
                for (int i = 0; i < 3; i++) begin
                    if (sel == 2'(i)) begin
                        cached_data[i] <= mem_dout;
                        cached_addr[i] <= lat_addr;
                        valid[i]       <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtdd_gfx_rom_arb.sv
// Bench for jtdd_gfx_rom_arb: directed plan steps plus a randomized phase,
// all checked against a slot-cache / round-robin reference model.
module tb_jtdd_gfx_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  csv;
    logic [31:0] ad [3];
    logic        mem_ack, mem_rdy;
    logic [15:0] mem_dout;

    logic [15:0] char_data, scr_data, obj_data;
    logic        char_ok, scr_ok, obj_ok;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [2:0]  ok_o;
    logic [15:0] dat_o [3];

    always #5 clk = ~clk;

    jtdd_gfx_rom_arb dut (
        .rst(rst), .clk(clk),
        .char_cs(csv[0]), .char_addr(ad[0][16:0]),
        .char_data(char_data), .char_ok(char_ok),
        .scr_cs(csv[1]), .scr_addr(ad[1][17:0]),
        .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(csv[2]), .obj_addr(ad[2][18:0]),
        .obj_data(obj_data), .obj_ok(obj_ok),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdy(mem_rdy), .mem_dout(mem_dout)
    );

    assign ok_o     = {obj_ok, scr_ok, char_ok};
    assign dat_o[0] = char_data;
    assign dat_o[1] = scr_data;
    assign dat_o[2] = obj_data;

    // reference model
    logic [31:0] offs [3] = '{32'h00000, 32'h20000, 32'h60000};
    bit          mvalid [3];
    logic [31:0] mca [3];
    logic [15:0] mcd [3];
    bit          mbusy, mreq;
    int          mslot, mrr;
    logic [31:0] mlat;
    logic [31:0] mma;
    int          npass = 0, ntot = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            mvalid[i] = 0; mca[i] = 0; mcd[i] = 0;
        end
        mbusy = 0; mreq = 0; mslot = 0; mrr = 0; mlat = 0; mma = 0;
    endtask

    function automatic bit mhit(int i);
        return csv[i] && mvalid[i] && (mca[i] == ad[i]);
    endfunction

    task automatic mcomplete();
        mvalid[mslot] = 1; mca[mslot] = mlat; mcd[mslot] = mem_dout;
        mbusy = 0;
    endtask

    // one clock: inputs held across the edge, model advanced, outputs checked
    task automatic cyc();
        bit found;
        @(negedge clk);
        if (rst) mreset();
        else if (!mbusy) begin
            found = 0;
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (mrr + k) % 3;
                if (!found && csv[j] && !mhit(j)) begin
                    found = 1; mslot = j;
                end
            end
            if (found) begin
                mbusy = 1; mreq = 1; mlat = ad[mslot];
                mma = (offs[mslot] + ad[mslot]) & 32'h3FFFFF;
                mrr = (mslot + 1) % 3;
            end
        end else if (mreq) begin
            if (mem_ack) begin
                mreq = 0;
                if (mem_rdy) mcomplete();
            end
        end else if (mem_rdy) mcomplete();
        chk("mem_req", {31'd0, mem_req}, {31'd0, mreq});
        if (mreq) chk("mem_addr", {10'd0, mem_addr}, mma);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ok%0d", i), {31'd0, ok_o[i]}, {31'd0, mhit(i)});
            chk($sformatf("data%0d", i), {16'd0, dat_o[i]}, {16'd0, mcd[i]});
        end
    endtask

    task automatic wait_req();
        for (int n = 0; n < 20 && !mem_req; n++) cyc();
        chk("req_timeout", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic serve(logic [31:0] exp, logic [15:0] d);
        wait_req();
        chk("serve_addr", {10'd0, mem_addr}, exp);
        mem_ack = 1; cyc(); mem_ack = 0;
        cyc(); cyc();
        mem_rdy = 1; mem_dout = d; cyc(); mem_rdy = 0;
    endtask

    initial begin
        rst = 1; csv = 0; ad[0] = 0; ad[1] = 0; ad[2] = 0;
        mem_ack = 0; mem_rdy = 0; mem_dout = 0;
        mreset();
        repeat (3) cyc();
        rst = 0;
        cyc();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {10'd0, mem_addr}, 32'd0);
        chk("rst_ok", {29'd0, ok_o}, 32'd0);

        // single object fetch
        csv[2] = 1; ad[2] = 32'h12345;
        cyc();
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", {10'd0, mem_addr}, 32'h72345);
        mem_ack = 1; cyc(); mem_ack = 0;
        mem_rdy = 1; mem_dout = 16'hBEEF; cyc(); mem_rdy = 0;
        chk("t1_ok", {31'd0, obj_ok}, 32'd1);
        chk("t1_data", {16'd0, obj_data}, 32'hBEEF);

        // cache hit, cs drop and restore
        repeat (4) cyc();
        chk("t2_noreq", {31'd0, mem_req}, 32'd0);
        csv[2] = 0; cyc();
        chk("t2_ok_off", {31'd0, obj_ok}, 32'd0);
        csv[2] = 1; cyc();
        chk("t2_ok_on", {31'd0, obj_ok}, 32'd1);
        chk("t2_noreq2", {31'd0, mem_req}, 32'd0);

        // round-robin
        csv = 3'b111; ad[0] = 32'h100; ad[1] = 32'h200; ad[2] = 32'h300;
        serve(32'h00100, 16'hA001);
        serve(32'h20200, 16'hA002);
        serve(32'h60300, 16'hA003);
        chk("t3_allok", {29'd0, ok_o}, 32'd7);
        ad[0] = 32'h101; ad[2] = 32'h301;
        serve(32'h00101, 16'hB001);
        serve(32'h60301, 16'hB003);
        chk("t3_allok2", {29'd0, ok_o}, 32'd7);

        // address change mid-fetch
        ad[0] = 32'h10;
        wait_req();
        chk("t4_addr", {10'd0, mem_addr}, 32'h00010);
        mem_ack = 1; cyc(); mem_ack = 0;
        ad[0] = 32'h11; cyc();
        mem_rdy = 1; mem_dout = 16'hC010; cyc(); mem_rdy = 0;
        chk("t4_ok_low", {31'd0, char_ok}, 32'd0);
        serve(32'h00011, 16'hC011);
        chk("t4_ok", {31'd0, char_ok}, 32'd1);
        chk("t4_data", {16'd0, char_data}, 32'hC011);

        // ack and rdy together
        ad[1] = 32'h222;
        wait_req();
        chk("t5_addr", {10'd0, mem_addr}, 32'h20222);
        mem_ack = 1; mem_rdy = 1; mem_dout = 16'h5A5A; cyc();
        mem_ack = 0; mem_rdy = 0;
        chk("t5_ok", {31'd0, scr_ok}, 32'd1);
        chk("t5_data", {16'd0, scr_data}, 32'h5A5A);
        cyc();
        chk("t5_idle", {31'd0, mem_req}, 32'd0);

        // reset while waiting, then a stray rdy
        ad[2] = 32'h333;
        wait_req();
        mem_ack = 1; cyc(); mem_ack = 0; cyc();
        rst = 1; #1;
        mreset();
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_ok", {29'd0, ok_o}, 32'd0);
        cyc();
        rst = 0; mem_rdy = 1; mem_dout = 16'hFFFF; cyc(); mem_rdy = 0;
        chk("t6_obj_data", {16'd0, obj_data}, 32'd0);
        chk("t6_char_data", {16'd0, char_data}, 32'd0);
        chk("t6_ok2", {29'd0, ok_o}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            mem_ack  = mreq ? 1'($urandom % 2) : 1'b0;
            mem_rdy  = mbusy ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_dout = 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom % 6 == 0) csv[i] = ~csv[i];
                if ($urandom % 6 == 0)
                    ad[i] = 32'h100 * (i + 1) + $urandom_range(0, 3);
            end
            cyc();
        end
        mem_ack = 0; mem_rdy = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
